seq_signed_divider: RTL and testbench
=====================================

SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

Interface
REQ-001 Parameter N SHALL default to 4 and be the operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled on a rising edge of clk.
REQ-005 dividend  input  N  signed two's-complement numerator; sampled only when start is accepted.
REQ-006 divisor  input  N  signed two's-complement denominator; sampled only when start is accepted.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  single-cycle pulse when results become valid.
REQ-009 quotient  output  N  signed quotient.
REQ-010 remainder  output  N  signed remainder.
REQ-011 div_by_zero  output  1  result flag; divisor was 0.
REQ-012 overflow  output  1  result flag; dividend = -2^(N-1) and divisor = -1.

Function
REQ-013 States SHALL be IDLE, CALC, FIX, DONE.
  - IDLE->CALC on start.
  - CALC->FIX after exactly N iterations.
  - FIX->DONE.
  - DONE->CALC if start, else IDLE.
REQ-014 start SHALL be accepted only in IDLE or DONE; start in CALC/FIX SHALL be ignored with no effect on the operation in progress.
REQ-015 On accept, operand signs SHALL be latched and magnitudes formed as N-bit unsigned; |-2^(N-1)| = 2^(N-1) SHALL be representable.
REQ-016 CALC SHALL perform one unsigned restoring shift-subtract step per cycle on an N+1-bit partial remainder, producing one quotient bit MSB-first.
REQ-017 FIX SHALL apply signs: quotient negated iff operand signs differ; remainder negated iff dividend negative.
  - Division truncates toward zero.
  - Dividend = quotient*divisor + remainder.
  - |remainder| < |divisor|.
REQ-018 done SHALL be high for exactly one cycle, N+2 clock edges after the accepting edge, independent of operand values.
REQ-019 busy SHALL be high in CALC and FIX only; busy and done SHALL never be high together.
REQ-020 quotient, remainder and flags SHALL update only on entry to DONE and hold until the next DONE.
REQ-021 Divisor = 0 SHALL still take N+2 cycles and SHALL give quotient = all ones (-1), remainder = dividend, div_by_zero = 1, overflow = 0.
REQ-022 Overflow case SHALL give quotient = -2^(N-1) (wrapped), remainder = 0, overflow = 1, div_by_zero = 0.
REQ-023 In all other cases both flags SHALL be 0.
REQ-024 Inputs dividend/divisor SHALL be ignored outside the accepting edge; changing them mid-operation SHALL not affect results.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, and busy, done, quotient, remainder, div_by_zero and overflow to 0, regardless of clk.
REQ-026 Reset mid-operation SHALL abort the operation with no done pulse afterwards.
REQ-027 The first start after release SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-028 Shared package div_pkg SHALL hold the state encoding (IDLE, CALC, FIX, DONE) and the iteration-counter width function clog2(N+1).
REQ-029 One combinational sub-module div_step SHALL implement a single shift-subtract-restore iteration:
  - inputs: partial remainder, next dividend bit, divisor magnitude.
  - outputs: new remainder, quotient bit.
REQ-030 The top level SHALL contain FSM, iteration counter, operand/sign registers and sign fix-up; no other sub-modules.

Verification (N=4)
REQ-031 start with 7 / 2 -> done at edge +6; quotient=3, remainder=1, flags 0; busy high edges +1..+5.
REQ-032 Sign matrix:
  - -7/2 -> q=-3, r=-1.
  - 7/-2 -> q=-3, r=1.
  - -7/-2 -> q=3, r=-1.
REQ-033 -8 / -1 -> q=-8, r=0, overflow=1; then 5 / 0 -> q=-1, r=5, div_by_zero=1, same N+2 latency.
REQ-034 start held high continuously, alternating operands -> start ignored during busy; restart accepted on the done edge; results back-to-back every N+2 cycles, each correct.
REQ-035 Assert rst_n low during CALC of 6/3 -> outputs 0 immediately, no done; then 6/3 after release -> q=2, r=0.
REQ-036 Exhaustive random sweep of all 256 operand pairs vs reference model -> zero mismatches, including flags.

Source files
------------

// File: rtl/seq_signed_divider_pkg.sv
// seq_signed_divider_pkg: state encoding and iteration-counter width shared by the divider files
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  function automatic int clog2_n1(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/seq_signed_divider_if.sv
// seq_signed_divider_if: divider request/result bundle
// master drives start/dividend/divisor; slave returns busy/done/quotient/remainder/div_by_zero/overflow
interface seq_signed_divider_if #(parameter int N = 4);
  logic start;
  logic [N-1:0] dividend, divisor;
  logic busy, done;
  logic [N-1:0] quotient, remainder;
  logic div_by_zero, overflow;
  modport master(output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero, overflow);
  modport slave(input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero, overflow);
endinterface

// File: rtl/seq_signed_divider_step.sv
// div_step: one unsigned restoring shift-subtract iteration
// rem_i partial remainder, bit_i next dividend bit, dsr_i divisor magnitude -> rem_o new remainder, q_o quotient bit
module div_step #(parameter int N = 4) (
  input  logic [N:0]   rem_i,
  input  logic         bit_i,
  input  logic [N-1:0] dsr_i,
  output logic [N:0]   rem_o,
  output logic         q_o
);
  logic [N+1:0] sh;
  assign sh = {rem_i, bit_i};
  assign q_o = sh >= {2'b00, dsr_i};
  assign rem_o = (N+1)'(q_o ? sh - {2'b00, dsr_i} : sh);
endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: sequential signed restoring divider, results N+2 cycles after accept
// clk, rst_n (async active-low), bus: slave side of seq_signed_divider_if
module seq_signed_divider
  import div_pkg::*;
#(parameter int N = 4) (
  input logic clk,
  input logic rst_n,
  seq_signed_divider_if.slave bus
);
  localparam int CW = clog2_n1(N);
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [N:0] rem_q, rem_d;
  logic [N-1:0] acc_q, acc_d, dsr_q, quo_q, rem_out_q, quo_fix, rem_fix;
  logic q_bit, sdd_q, sdr_q, zero_q, ovf_q, busy_q, done_q, dz_q, ov_q;
  // acc_q shifts dividend bits out of the top while quotient bits enter at the bottom
  div_step #(.N(N)) u_step (.rem_i(rem_q), .bit_i(acc_q[N-1]), .dsr_i(dsr_q), .rem_o(rem_d), .q_o(q_bit));
  assign acc_d = {acc_q[N-2:0], q_bit};
  // divide-by-zero yields all-ones magnitude; force -1 so the sign fix-up cannot flip it
  assign quo_fix = zero_q ? '1 : (sdd_q ^ sdr_q) ? -acc_q : acc_q;
  assign rem_fix = N'(sdd_q ? -rem_q : rem_q);
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.quotient = quo_q;
  assign bus.remainder = rem_out_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow = ov_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      acc_q <= '0;
      dsr_q <= '0;
      sdd_q <= 1'b0;
      sdr_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q <= '0;
      rem_out_q <= '0;
      dz_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        CALC: begin
          rem_q <= rem_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_q <= FIX;
        end
        FIX: begin
          state_q <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          quo_q <= quo_fix;
          rem_out_q <= rem_fix;
          dz_q <= zero_q;
          ov_q <= ovf_q;
        end
        default: begin
          state_q <= bus.start ? CALC : IDLE;
          busy_q <= bus.start;
          if (bus.start) begin
            cnt_q <= '0;
            rem_q <= '0;
            acc_q <= bus.dividend[N-1] ? -bus.dividend : bus.dividend;
            dsr_q <= bus.divisor[N-1] ? -bus.divisor : bus.divisor;
            sdd_q <= bus.dividend[N-1];
            sdr_q <= bus.divisor[N-1];
            zero_q <= bus.divisor == '0;
            ovf_q <= bus.dividend == {1'b1, {(N-1){1'b0}}} && bus.divisor == '1;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: randomized and directed checks of seq_signed_divider against an arithmetic model
module tb_seq_signed_divider;
  localparam int N = 4;
  typedef struct packed {logic [N-1:0] q, r; logic dz, ov;} res_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_tests = 0, n_fail = 0;
  res_t m_out = '0, pend = '0, pin;
  logic m_busy = 1'b0, m_done = 1'b0, pending = 1'b0;
  int cyc = 0, acc_cyc = 0, nd, last, lat, pa, pb, qa, qb, sweep_done;
  int perm[256];
  seq_signed_divider_if #(.N(N)) bus ();
  seq_signed_divider #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // truncating signed division straight from the arithmetic definition
  function automatic res_t ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
    int sa, sb;
    res_t o;
    sa = $signed(a);
    sb = $signed(b);
    o = '0;
    if (sb == 0) begin
      o.q = '1;
      o.r = a;
      o.dz = 1'b1;
    end else if (sa == -(2 ** (N - 1)) && sb == -1) begin
      o.q = N'(-(2 ** (N - 1)));
      o.ov = 1'b1;
    end else begin
      o.q = N'(sa / sb);
      o.r = N'(sa % sb);
    end
    return o;
  endfunction

  // timing model: accepted when no division is pending, result appears N+1 edges later
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pending = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_out = '0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (pending && cyc == acc_cyc + N + 1) begin
        pending = 1'b0;
        m_busy = 1'b0;
        m_done = 1'b1;
        m_out = pend;
      end else if (!pending && bus.start) begin
        pending = 1'b1;
        m_busy = 1'b1;
        acc_cyc = cyc;
        pend = ref_div(bus.dividend, bus.divisor);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("quotient", $signed(bus.quotient), $signed(m_out.q));
      check("remainder", $signed(bus.remainder), $signed(m_out.r));
      check("div_by_zero", bus.div_by_zero, m_out.dz);
      check("overflow", bus.overflow, m_out.ov);
    end
  end

  task automatic run(input int a, input int b, output int l);
    bus.start = 1'b1;
    bus.dividend = N'(a);
    bus.divisor = N'(b);
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.dividend = N'($urandom);
    bus.divisor = N'($urandom);
    l = 0;
    while (l < 4 * N) begin
      @(posedge clk);
      l++;
      @(negedge clk);
      if (bus.done) break;
    end
    // done seen after edge l is sampled high at edge l+1
    l = bus.done ? l + 1 : -1;
    check("latency", l, N + 2);
  endtask

  task automatic directed(input int a, input int b, input int eq, input int er, input int edz, input int eov);
    int l;
    run(a, b, l);
    check($sformatf("q %0d/%0d", a, b), $signed(bus.quotient), eq);
    check($sformatf("r %0d/%0d", a, b), $signed(bus.remainder), er);
    check($sformatf("flags %0d/%0d", a, b), {bus.div_by_zero, bus.overflow}, edz * 2 + eov);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    pin = ref_div(N'(7), N'(2));
    check("model 7/2", {pin.q, pin.r}, {4'd3, 4'd1});
    pin = ref_div(N'(-7), N'(-2));
    check("model -7/-2", {pin.q, pin.r}, {4'd3, 4'b1111});
    pin = ref_div(N'(-8), N'(0));
    check("model -8/0", {pin.q, pin.r, pin.dz, pin.ov}, {4'b1111, 4'b1000, 2'b10});
    repeat (2) @(posedge clk);
    #1 check("reset_state", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, 0);
    @(negedge clk) rst_n = 1'b1;
    directed(7, 2, 3, 1, 0, 0);
    directed(-7, 2, -3, -1, 0, 0);
    directed(7, -2, -3, 1, 0, 0);
    directed(-7, -2, 3, -1, 0, 0);
    directed(-8, -1, -8, 0, 0, 1);
    directed(5, 0, -1, 5, 1, 0);
    directed(-8, 1, -8, 0, 0, 0);
    directed(-8, 0, -1, -8, 1, 0);
    // start held high: restarts only on done edges, results every N+2 cycles
    pa = $urandom; pb = $urandom; qa = $urandom; qb = $urandom;
    bus.start = 1'b1;
    bus.dividend = N'(pa);
    bus.divisor = N'(pb);
    nd = 0;
    last = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        nd++;
        if (last >= 0) check("b2b_spacing", i - last, N + 2);
        last = i;
      end
      bus.dividend = N'(i % 2 ? qa : pa);
      bus.divisor = N'(i % 2 ? qb : pb);
    end
    bus.start = 1'b0;
    check("b2b_count", nd, 6);
    repeat (2 * N) @(negedge clk);
    // reset during CALC aborts silently
    bus.start = 1'b1;
    bus.dividend = N'(6);
    bus.divisor = N'(3);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_abort", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    repeat (2 * N + 4) begin
      @(negedge clk);
      nd += int'(bus.done);
    end
    check("no_done_after_abort", nd, 0);
    @(negedge clk) rst_n = 1'b0;
    #2 rst_n = 1'b1;
    directed(6, 3, 2, 0, 0, 0);
    // all operand pairs in shuffled order
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    sweep_done = 0;
    for (int i = 0; i < 256; i++) begin
      run(perm[i] / 16, perm[i] % 16, lat);
      if (lat == N + 2) sweep_done++;
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    check("sweep_done_count", sweep_done, 256);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
